// File: rtl/tblock_dispatcher.sv
// Kernel-level thread-block dispatcher: issues one allocation per block to a compute
// unit, hands out in-flight ids from a free pool and reports kernel completion.
module tblock_dispatcher #(
    parameter int PcWidth       = 32,
    parameter int AddressWidth  = 32,
    parameter int TblockIdxBits = 4,
    parameter int TblockIdBits  = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     kernel_valid_i,
    output logic                     kernel_ready_o,
    input  logic [PcWidth-1:0]       kernel_pc_i,
    input  logic [AddressWidth-1:0]  kernel_dp_addr_i,
    input  logic [TblockIdxBits:0]   kernel_num_blocks_i,
    output logic                     kernel_done_o,
    input  logic                     kernel_done_ready_i,
    output logic                     busy_o,
    input  logic                     warp_free_i,
    output logic                     allocate_warp_o,
    output logic [PcWidth-1:0]       allocate_pc_o,
    output logic [AddressWidth-1:0]  allocate_dp_addr_o,
    output logic [TblockIdxBits-1:0] allocate_tblock_idx_o,
    output logic [TblockIdBits-1:0]  allocate_tblock_id_o,
    input  logic                     tblock_done_i,
    input  logic [TblockIdBits-1:0]  tblock_done_id_i,
    output logic                     tblock_done_ready_o,
    output logic                     err_done_o,
    output logic [1:0]               dbg_state_o
);
    localparam int NumIds = 1 << TblockIdBits;
    localparam int CntW   = TblockIdxBits + 1;
    localparam logic [CntW-1:0] MaxBlocks = CntW'(1 << TblockIdxBits);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DISPATCH = 2'd1,
        DRAIN    = 2'd2,
        DONE     = 2'd3
    } state_e;

    state_e                  state_q;
    logic                    kernel_ready_q, kernel_done_q, busy_q, err_done_q;
    logic [PcWidth-1:0]      pc_q;
    logic [AddressWidth-1:0] dp_addr_q;
    logic [CntW-1:0]         total_q, issued_q, issued_d, retired_q, retired_d, launch_total;
    logic [NumIds-1:0]       inflight_q, inflight_d;
    logic [TblockIdBits-1:0] free_id;
    logic                    free_found, alloc, done_hit;

    // Lowest clear bit of the in-flight bitmap, taken before this cycle's updates.
    always_comb begin
        free_id    = '0;
        free_found = 1'b0;
        for (int i = 0; i < NumIds; i++) begin
            if (!inflight_q[i] && !free_found) begin
                free_id    = TblockIdBits'(i);
                free_found = 1'b1;
            end
        end
    end

    assign alloc        = (state_q == DISPATCH) && warp_free_i && free_found;
    assign done_hit     = tblock_done_i && inflight_q[tblock_done_id_i];
    assign issued_d     = issued_q + CntW'(alloc);
    assign retired_d    = retired_q + CntW'(done_hit);
    assign launch_total = (kernel_num_blocks_i > MaxBlocks) ? MaxBlocks : kernel_num_blocks_i;

    // Allocated id was free before the update, so it never collides with the retiring id.
    always_comb begin
        inflight_d = inflight_q;
        if (done_hit) inflight_d[tblock_done_id_i] = 1'b0;
        if (alloc)    inflight_d[free_id]          = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q        <= IDLE;
            kernel_ready_q <= 1'b1;
            kernel_done_q  <= 1'b0;
            busy_q         <= 1'b0;
            err_done_q     <= 1'b0;
            pc_q           <= '0;
            dp_addr_q      <= '0;
            total_q        <= '0;
            issued_q       <= '0;
            retired_q      <= '0;
            inflight_q     <= '0;
        end else begin
            inflight_q <= inflight_d;
            issued_q   <= issued_d;
            retired_q  <= retired_d;
            err_done_q <= tblock_done_i && !inflight_q[tblock_done_id_i];
            case (state_q)
                IDLE: begin
                    if (kernel_valid_i) begin
                        pc_q           <= kernel_pc_i;
                        dp_addr_q      <= kernel_dp_addr_i;
                        total_q        <= launch_total;
                        issued_q       <= '0;
                        retired_q      <= '0;
                        kernel_ready_q <= 1'b0;
                        busy_q         <= 1'b1;
                        if (launch_total == '0) begin
                            state_q       <= DONE;
                            kernel_done_q <= 1'b1;
                        end else begin
                            state_q <= DISPATCH;
                        end
                    end
                end
                DISPATCH: begin
                    if (issued_d == total_q) state_q <= DRAIN;
                end
                DRAIN: begin
                    if (retired_d == total_q) begin
                        state_q       <= DONE;
                        kernel_done_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (kernel_done_ready_i) begin
                        state_q        <= IDLE;
                        kernel_done_q  <= 1'b0;
                        kernel_ready_q <= 1'b1;
                        busy_q         <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign kernel_ready_o        = kernel_ready_q;
    assign kernel_done_o         = kernel_done_q;
    assign busy_o                = busy_q;
    assign allocate_warp_o       = alloc;
    assign allocate_pc_o         = pc_q;
    assign allocate_dp_addr_o    = dp_addr_q;
    assign allocate_tblock_idx_o = issued_q[TblockIdxBits-1:0];
    assign allocate_tblock_id_o  = free_id;
    assign tblock_done_ready_o   = 1'b1;
    assign err_done_o            = err_done_q;
    assign dbg_state_o           = state_q;
endmodule

// File: doc/tblock_dispatcher.md
Name: tblock_dispatcher

Overview:
- Kernel-level scheduler in front of one compute unit's warp-allocation and thread-block-completion interface.
- Accepts a kernel launch (start PC, data/parameter address, block count) and issues one allocation per thread block whenever the compute unit reports a free warp.
- Assigns each block a sequential block index and a unique in-flight block id from a free pool, and recycles ids on completion.
- Signals kernel completion once every dispatched block has retired.

Parameters:
PcWidth, 32, program counter width
AddressWidth, 32, data/parameter address width
TblockIdxBits, 4, block index width; max blocks per kernel = 2^TblockIdxBits
TblockIdBits, 4, block id width; max in-flight blocks = 2^TblockIdBits

Ports:
clk_i  in  1  clock; single clock domain
rst_i  in  1  reset, synchronous, active-high
kernel_valid_i  in  1  launch request valid
kernel_ready_o  out  1  launch accepted (high only in IDLE)
kernel_pc_i  in  PcWidth  kernel start PC
kernel_dp_addr_i  in  AddressWidth  data/parameter address
kernel_num_blocks_i  in  TblockIdxBits+1  number of blocks
kernel_done_o  out  1  kernel complete, held until kernel_done_ready_i
kernel_done_ready_i  in  1  completion consumed
busy_o  out  1  state != IDLE
warp_free_i  in  1  compute unit has at least one free warp
allocate_warp_o  out  1  allocate one block this cycle
allocate_pc_o  out  PcWidth  latched kernel PC
allocate_dp_addr_o  out  AddressWidth  latched dp address
allocate_tblock_idx_o  out  TblockIdxBits  block index
allocate_tblock_id_o  out  TblockIdBits  block id
tblock_done_i  in  1  compute unit reports a block finished
tblock_done_id_i  in  TblockIdBits  id of the finished block
tblock_done_ready_o  out  1  completion accepted; constant 1 out of reset
err_done_o  out  1  one-cycle pulse: completion for an id not in flight

Behaviour:
- Clock and reset: clk_i is the only clock. Synchronous active-high rst_i clears the FSM to IDLE, all counters, the in-flight bitmap and the latched kernel registers.
- Reset values: kernel_ready_o=1 (IDLE), all other outputs 0 except tblock_done_ready_o=1.
- FSM states: IDLE, DISPATCH, DRAIN, DONE.
- IDLE:
  - kernel_ready_o=1.
  - On kernel_valid_i, latch pc and dp_addr, set total = min(kernel_num_blocks_i, 2^TblockIdxBits), and clear issued/retired counters.
  - Next state: DISPATCH if total>0, else DONE (kernel_done_o high the following cycle).
- DISPATCH:
  - allocate_warp_o = warp_free_i & (inflight bitmap not full); combinational, no handshake beyond warp_free_i. Each asserted cycle is one allocation; at most one per cycle.
  - allocate_tblock_idx_o = issued count (low TblockIdxBits bits), so blocks are numbered 0..total-1 in order.
  - allocate_tblock_id_o = lowest-index clear bit of the bitmap, evaluated before this cycle's update. That bit is set on allocate.
  - Leave to DRAIN in the cycle issued reaches total.
- DRAIN: no allocations; wait until retired == total, then go to DONE.
- DONE: kernel_done_o=1 until kernel_done_ready_i, then go to IDLE. kernel_ready_o is 0 during DONE, so a new launch is accepted no earlier than the cycle after the handshake.
- Completion handling (any state):
  - When tblock_done_i and the bitmap bit for tblock_done_id_i is set: clear the bit and increment retired.
  - When the bit is clear: no state change, and err_done_o pulses for one cycle.
- Simultaneous allocate and completion in one cycle: both bitmap updates apply. The allocated id cannot equal the completed id, because the allocated id was free before the update.
- Counters: issued and retired are TblockIdxBits+1 bits wide and never wrap, since total ≤ 2^TblockIdxBits.
- Bitmap full (2^TblockIdBits blocks in flight): allocate_warp_o=0 regardless of warp_free_i. Dispatch resumes the cycle after any completion frees a bit.
- Reset mid-kernel: all tracking is lost. Later completions for pre-reset ids raise err_done_o and are otherwise ignored.
- Latency:
  - Launch accept → first possible allocate: 1 cycle.
  - Final completion → kernel_done_o: 1 cycle (DRAIN → DONE).
  - Last allocate and its completion in the same cycle: DISPATCH → DRAIN, then DONE one cycle later.

Test Plan:
1. Launch pc=0x100, dp=0x2000, num_blocks=3, warp_free_i=1 constant, completions 5 cycles after each allocate → three allocates in consecutive cycles with idx 0,1,2 and ids 0,1,2; kernel_done_o one cycle after the third completion; kernel_ready_o=1 after the handshake.
2. num_blocks=0 → no allocate; kernel_done_o asserts 1 cycle after accept; held 3 cycles while kernel_done_ready_i=0, released on ready.
3. TblockIdBits=2, num_blocks=6, no completions → exactly 4 allocates (ids 0..3) then stall. Complete id 2 → next allocate uses id 2, idx 4.
4. tblock_done_i with id 3 when not in flight → err_done_o pulses for 1 cycle; retired count and bitmap unchanged; kernel still finishes correctly.
5. num_blocks=31 with TblockIdxBits=4 → clamped to 16 allocates, idx 0..15; done after 16 completions.
6. rst_i asserted mid-DISPATCH with 2 blocks in flight → next cycle IDLE, all outputs at reset values. Subsequent completions of those ids pulse err_done_o; a new launch proceeds from idx 0, id 0.
